// File: rtl/bmatch_sig_engine.sv
// rtl/bmatch_sig_engine.sv - sequential signature engine for N_IN-input AND/OR matching cones.
// Drives an exhaustive or LFSR pattern stream and shifts every cone output into a per-channel signature.
module bmatch_sig_engine #(
  parameter int          N_IN    = 4,
  parameter int          SIG_LEN = 32,
  parameter logic [15:0] SEED    = 16'hACE1,
  localparam int         CH      = N_IN - 1,
  localparam int         CW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  output logic               busy,
  output logic               done,
  output logic [N_IN-1:0]    cur_pat,
  input  logic [CW-1:0]      rd_ch,
  output logic [SIG_LEN-1:0] rd_and_sig,
  output logic [SIG_LEN-1:0] rd_or_sig
);

  localparam int RW    = $clog2(SIG_LEN + 1);
  localparam int NSLOT = 2 ** CW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state;
  logic               mode_q;
  logic [N_IN-1:0]    pcnt;
  logic [15:0]        lfsr;
  logic [RW-1:0]      rcnt;
  logic [N_IN-1:0]    src;
  logic               fb;
  // Slots past CH are never shifted; they keep the read mux index in range.
  logic [SIG_LEN-1:0] and_sig [NSLOT];
  logic [SIG_LEN-1:0] or_sig  [NSLOT];

  assign src     = mode_q ? lfsr[N_IN-1:0] : pcnt;
  assign fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign cur_pat = (state == S_RUN) ? src : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      mode_q <= 1'b0;
      pcnt   <= '0;
      lfsr   <= SEED;
      rcnt   <= '0;
      for (int k = 0; k < NSLOT; k++) begin
        and_sig[k] <= '0;
        or_sig[k]  <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            mode_q <= mode;
            pcnt   <= '0;
            lfsr   <= SEED;
            rcnt   <= '0;
            for (int k = 0; k < NSLOT; k++) begin
              and_sig[k] <= '0;
              or_sig[k]  <= '0;
            end
          end
        end
        S_RUN: begin
          for (int k = 0; k < CH; k++) begin
            and_sig[k] <= {and_sig[k][SIG_LEN-2:0], src[N_IN-1] & src[k]};
            or_sig[k]  <= {or_sig[k][SIG_LEN-2:0],  src[N_IN-1] | src[k]};
          end
          pcnt <= pcnt + 1'b1;
          lfsr <= {lfsr[14:0], fb};
          rcnt <= rcnt + 1'b1;
          if (rcnt == RW'(SIG_LEN - 1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_and_sig = '0;
    rd_or_sig  = '0;
    if (int'(rd_ch) < CH) begin
      rd_and_sig = and_sig[rd_ch];
      rd_or_sig  = or_sig[rd_ch];
    end
  end

endmodule
